// File: rtl/regfile_psr.sv
// Operand-fetch / write-back stage: general-purpose register file, PSR, write counter and B-operand immediate mux.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto A_out/B_out.
module regfile_psr #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int IMM_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        ra_addr,
    input  logic [3:0]        rb_addr,
    input  logic [IMM_W-1:0]  imm,
    input  logic              imm_sel,
    input  logic              imm_sext,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        flags_in,
    input  logic [4:0]        flags_we,
    output logic [4:0]        psr_out,
    output logic [15:0]       wr_count
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [4:0]        psr;
    logic [15:0]       count;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    // Sign- or zero-extend the immediate field to operand width.
    function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] value,
                                                     input logic sext);
        logic signed [IMM_W-1:0]  sval;
        logic signed [DATA_W-1:0] wide;
        sval = value;
        wide = sval;
        extend_imm = sext ? wide : {{(DATA_W-IMM_W){1'b0}}, value};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            psr   <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
                count         <= count + 16'd1;
            end
            for (int i = 0; i < 5; i++) begin
                if (flags_we[i]) begin
                    psr[i] <= flags_in[i];
                end
            end
        end
    end

    always_comb begin
        a_reg = regs[ra_addr];
        b_reg = regs[rb_addr];
`ifdef REGFILE_BYPASS_EN
        // Write-through lets a dependent instruction consume its producer's result without a stall.
        if (wr_en && !reset && (wr_addr == ra_addr)) begin
            a_reg = wr_data;
        end
        if (wr_en && !reset && (wr_addr == rb_addr)) begin
            b_reg = wr_data;
        end
`else
        a_reg = regs[ra_addr];
        b_reg = regs[rb_addr];
`endif
    end

    always_comb begin
        A_out = a_reg;
        B_out = imm_sel ? extend_imm(imm, imm_sext) : b_reg;
    end

    assign psr_out  = psr;
    assign wr_count = count;

endmodule
